// File: rtl/pipe_ctrl.sv
// Hazard controller for the F/D/E/M/W core: load-use stalls, branch/jump redirect,
// mul/div start/done sequencing with a watchdog, and cycle/stall/flush counters.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module pipe_ctrl #(
  parameter int CNT_WIDTH  = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           D_rs1_i,
  input  logic [4:0]           D_rs2_i,
  input  logic                 D_use_rs1_i,
  input  logic                 D_use_rs2_i,
  input  logic                 E_valid_i,
  input  logic [8:0]           E_op_info_i,
  input  logic [4:0]           E_rd_i,
  input  logic                 E_md_i,
  input  logic                 e_cnd_i,
  input  logic [`PC_WIDTH-1:0] e_target_i,
  input  logic                 md_done_i,
  output logic                 md_start_o,
  output logic                 md_err_o,
  output logic                 F_stall_o,
  output logic                 D_stall_o,
  output logic                 E_stall_o,
  output logic                 D_bubble_o,
  output logic                 E_bubble_o,
  output logic                 M_bubble_o,
  output logic                 f_redirect_o,
  output logic [`PC_WIDTH-1:0] f_redirect_pc_o,
  output logic [CNT_WIDTH-1:0] cnt_cycle_o,
  output logic [CNT_WIDTH-1:0] cnt_stall_o,
  output logic [CNT_WIDTH-1:0] cnt_flush_o
);

  // state   | meaning
  // S_IDLE  | no mul/div in flight; pipe steered by redirect / load-use
  // S_BUSY  | mul/div running; waiting for done or watchdog expiry
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam int WD_W = $clog2(MD_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [CNT_WIDTH-1:0] cnt_cycle_q, cnt_stall_q, cnt_flush_q;

  logic md_req, taken, load_use;
  logic op_unused;

  assign op_unused = ^{E_op_info_i[8:7], E_op_info_i[3], E_op_info_i[1:0]};

  assign md_req = E_valid_i & E_md_i;
  assign taken  = E_valid_i & ((E_op_info_i[4] & e_cnd_i) | E_op_info_i[5] | E_op_info_i[6]);
  assign load_use = E_valid_i & E_op_info_i[2] & (E_rd_i != 5'd0) &
                    ((D_use_rs1_i & (D_rs1_i == E_rd_i)) | (D_use_rs2_i & (D_rs2_i == E_rd_i)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      cnt_cycle_q <= '0;
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      cnt_cycle_q <= cnt_cycle_q + 1'b1;
      cnt_stall_q <= cnt_stall_q + CNT_WIDTH'(F_stall_o);
      cnt_flush_q <= cnt_flush_q + CNT_WIDTH'(f_redirect_o);
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (md_req) begin
          state_d = S_BUSY;
          wd_d    = '0;
        end
      end
      S_BUSY: begin
        if (md_done_i || (wd_q == WD_LAST)) state_d = S_IDLE;
        else                                wd_d    = wd_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mul/div owns the pipe in its start cycle and every BUSY cycle; redirect beats load-use.
  always_comb begin
    md_start_o      = 1'b0;
    md_err_o        = 1'b0;
    F_stall_o       = 1'b0;
    D_stall_o       = 1'b0;
    E_stall_o       = 1'b0;
    D_bubble_o      = 1'b0;
    E_bubble_o      = 1'b0;
    M_bubble_o      = 1'b0;
    f_redirect_o    = 1'b0;
    f_redirect_pc_o = '0;
    if (rst_n) begin
      if (state_q == S_BUSY) begin
        if (!md_done_i) begin
          if (wd_q == WD_LAST) begin
            md_err_o   = 1'b1;
            M_bubble_o = 1'b1;
          end else begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_stall_o  = 1'b1;
            M_bubble_o = 1'b1;
          end
        end
      end else if (md_req) begin
        md_start_o = 1'b1;
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_stall_o  = 1'b1;
        M_bubble_o = 1'b1;
      end else if (taken) begin
        f_redirect_o    = 1'b1;
        f_redirect_pc_o = e_target_i;
        D_bubble_o      = 1'b1;
        E_bubble_o      = 1'b1;
      end else if (load_use) begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_bubble_o = 1'b1;
      end
    end
  end

  assign cnt_cycle_o = rst_n ? cnt_cycle_q : '0;
  assign cnt_stall_o = rst_n ? cnt_stall_q : '0;
  assign cnt_flush_o = rst_n ? cnt_flush_q : '0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard/mul-div scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module tb_pipe_ctrl;

  localparam int CW     = 8;
  localparam int MD_TO  = 4;
  localparam int CMOD   = 256;

  typedef struct packed {
    logic start, err, fs, ds, es, db, eb, mb, redir;
    logic [`PC_WIDTH-1:0] pc;
    logic [CW-1:0] cc, cs, cf;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] D_rs1, D_rs2, E_rd;
  logic D_use1, D_use2, E_valid, E_md, e_cnd, md_done;
  logic [8:0] E_op;
  logic [`PC_WIDTH-1:0] e_target;
  logic md_start, md_err, F_stall, D_stall, E_stall, D_bubble, E_bubble, M_bubble, f_redirect;
  logic [`PC_WIDTH-1:0] f_redirect_pc;
  logic [CW-1:0] cnt_cycle, cnt_stall, cnt_flush;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_WIDTH(CW), .MD_TIMEOUT(MD_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_rs1_i(D_rs1), .D_rs2_i(D_rs2), .D_use_rs1_i(D_use1), .D_use_rs2_i(D_use2),
    .E_valid_i(E_valid), .E_op_info_i(E_op), .E_rd_i(E_rd), .E_md_i(E_md),
    .e_cnd_i(e_cnd), .e_target_i(e_target), .md_done_i(md_done),
    .md_start_o(md_start), .md_err_o(md_err),
    .F_stall_o(F_stall), .D_stall_o(D_stall), .E_stall_o(E_stall),
    .D_bubble_o(D_bubble), .E_bubble_o(E_bubble), .M_bubble_o(M_bubble),
    .f_redirect_o(f_redirect), .f_redirect_pc_o(f_redirect_pc),
    .cnt_cycle_o(cnt_cycle), .cnt_stall_o(cnt_stall), .cnt_flush_o(cnt_flush)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model: is a mul/div in flight, which BUSY cycle this is, and event tallies.
  bit m_busy   = 0;
  int m_busy_n = 0;
  int m_cyc = 0, m_stall = 0, m_flush = 0;

  outs_t act, exp_o;

  function automatic outs_t model_out();
    outs_t o;
    bit taken, lu;
    o = '0;
    if (!rst_n) return o;
    o.cc = CW'(m_cyc);
    o.cs = CW'(m_stall);
    o.cf = CW'(m_flush);
    taken = E_valid && ((E_op[4] && e_cnd) || E_op[5] || E_op[6]);
    lu = E_valid && E_op[2] && (E_rd != 0) &&
         ((D_use1 && D_rs1 == E_rd) || (D_use2 && D_rs2 == E_rd));
    if (m_busy) begin
      if (!md_done) begin
        if (m_busy_n == MD_TO) begin
          o.err = 1; o.mb = 1;
        end else begin
          o.fs = 1; o.ds = 1; o.es = 1; o.mb = 1;
        end
      end
    end else if (E_valid && E_md) begin
      o.start = 1; o.fs = 1; o.ds = 1; o.es = 1; o.mb = 1;
    end else if (taken) begin
      o.redir = 1; o.pc = e_target; o.db = 1; o.eb = 1;
    end else if (lu) begin
      o.fs = 1; o.ds = 1; o.eb = 1;
    end
    return o;
  endfunction

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled mid-cycle.
  task automatic run_cycle();
    #4;
    exp_o = model_out();
    act.start = md_start;  act.err = md_err;
    act.fs = F_stall;      act.ds = D_stall;   act.es = E_stall;
    act.db = D_bubble;     act.eb = E_bubble;  act.mb = M_bubble;
    act.redir = f_redirect; act.pc = f_redirect_pc;
    act.cc = cnt_cycle;    act.cs = cnt_stall; act.cf = cnt_flush;
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_busy_n = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_cyc   = (m_cyc + 1) % CMOD;
      m_stall = (m_stall + int'(exp_o.fs)) % CMOD;
      m_flush = (m_flush + int'(exp_o.redir)) % CMOD;
      if (m_busy) begin
        if (md_done || m_busy_n == MD_TO) m_busy = 0;
        else m_busy_n++;
      end else if (exp_o.start) begin
        m_busy = 1; m_busy_n = 1;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    D_rs1 = 0; D_rs2 = 0; D_use1 = 0; D_use2 = 0;
    E_valid = 0; E_op = 0; E_rd = 0; E_md = 0; e_cnd = 0; e_target = 0; md_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    run_cycle();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      D_rs1 = 5'd3; D_rs2 = 5'd3; D_use1 = 1; D_use2 = 1; E_valid = 1;
      E_op = 9'h074; E_rd = 5'd3; E_md = i[0]; e_cnd = 1; e_target = $urandom; md_done = 1;
      run_cycle();
      n_checks++;
      if (act !== '0) begin
        n_fails++;
        $display("FAIL reset_outputs: got %h want 0", act);
      end
    end
    clear_inputs();
    rst_n = 1;
    run_cycle();
    n_checks++;
    if (act.cc !== 0 || act.cs !== 0 || act.cf !== 0) begin
      n_fails++;
      $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", act.cc, act.cs, act.cf);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    E_valid = 1; E_op = 9'h004; E_rd = 5'd5; D_rs2 = 5'd5; D_use2 = 1;
    run_cycle();
    n_checks++;
    if ({act.fs, act.ds, act.eb, act.es, act.redir} !== 5'b11100) begin
      n_fails++;
      $display("FAIL load_use: got fs/ds/eb/es/redir=%b want 11100",
               {act.fs, act.ds, act.eb, act.es, act.redir});
    end
    E_rd = 5'd0; D_rs2 = 5'd0;
    run_cycle();
    n_checks++;
    if (act.cs !== 8'd1) begin
      n_fails++;
      $display("FAIL load_use_cnt_stall: got %0d want 1", act.cs);
    end
    n_checks++;
    if (act.fs !== 1'b0 || act.eb !== 1'b0) begin
      n_fails++;
      $display("FAIL load_use_rd0: got fs=%b eb=%b want 0 0", act.fs, act.eb);
    end
  endtask

  task automatic test_branch();
    do_reset();
    E_valid = 1; E_op = 9'h010; e_cnd = 1; e_target = 32'h8000_0040;
    run_cycle();
    n_checks++;
    if (act.redir !== 1'b1 || act.pc !== 32'h8000_0040 || act.db !== 1'b1 ||
        act.eb !== 1'b1 || act.cf !== 8'd0) begin
      n_fails++;
      $display("FAIL branch_taken: got redir=%b pc=%h db=%b eb=%b cf=%0d want 1 80000040 1 1 0",
               act.redir, act.pc, act.db, act.eb, act.cf);
    end
    e_cnd = 0;
    run_cycle();
    n_checks++;
    if (act.cf !== 8'd1) begin
      n_fails++;
      $display("FAIL branch_cnt_flush: got %0d want 1", act.cf);
    end
    n_checks++;
    if ({act.start, act.err, act.fs, act.ds, act.es, act.db, act.eb, act.mb, act.redir} !== 9'b0 ||
        act.pc !== '0) begin
      n_fails++;
      $display("FAIL branch_not_taken: got ctl=%b pc=%h want 0 0",
               {act.start, act.err, act.fs, act.ds, act.es, act.db, act.eb, act.mb, act.redir}, act.pc);
    end
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    E_valid = 1; E_op = 9'h044; E_rd = 5'd5; D_rs1 = 5'd5; D_use1 = 1; e_target = 32'h0000_1234;
    run_cycle();
    n_checks++;
    if (act.redir !== 1'b1 || act.pc !== 32'h0000_1234 || act.fs !== 1'b0 || act.ds !== 1'b0) begin
      n_fails++;
      $display("FAIL redir_lu: got redir=%b pc=%h fs=%b ds=%b want 1 00001234 0 0",
               act.redir, act.pc, act.fs, act.ds);
    end
    clear_inputs();
    run_cycle();
    n_checks++;
    if (act.cs !== 8'd0 || act.cf !== 8'd1) begin
      n_fails++;
      $display("FAIL redir_lu_counters: got cs=%0d cf=%0d want 0 1", act.cs, act.cf);
    end
  endtask

  task automatic test_md_normal();
    logic [3:0] starts, stalls, mbs;
    do_reset();
    E_valid = 1; E_md = 1; E_op = 9'h010; e_cnd = 1;
    starts = 0; stalls = 0; mbs = 0;
    for (int i = 0; i < 4; i++) begin
      md_done = (i == 3);
      run_cycle();
      starts[i] = act.start; stalls[i] = act.fs & act.ds & act.es; mbs[i] = act.mb;
      n_checks++;
      if (act.redir !== 1'b0) begin
        n_fails++;
        $display("FAIL md_redirect_suppressed: cycle %0d got %b want 0", i, act.redir);
      end
    end
    clear_inputs();
    run_cycle();
    n_checks++;
    if (starts !== 4'b0001 || stalls !== 4'b0111 || mbs !== 4'b0111) begin
      n_fails++;
      $display("FAIL md_normal: got start=%b stall=%b mb=%b want 0001 0111 0111", starts, stalls, mbs);
    end
    n_checks++;
    if (act.cs !== 8'd3 || act.start !== 1'b0) begin
      n_fails++;
      $display("FAIL md_normal_cnt: got cs=%0d start=%b want 3 0", act.cs, act.start);
    end
  endtask

  task automatic test_md_timeout();
    logic [4:0] errs, mbs, es;
    do_reset();
    E_valid = 1; E_md = 1;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      errs[i] = act.err; mbs[i] = act.mb; es[i] = act.es;
    end
    n_checks++;
    if (errs !== 5'b10000 || mbs !== 5'b11111 || es !== 5'b01111) begin
      n_fails++;
      $display("FAIL md_timeout: got err=%b mb=%b es=%b want 10000 11111 01111", errs, mbs, es);
    end
    E_md = 0;
    run_cycle();
    n_checks++;
    if (act.err !== 1'b0 || act.fs !== 1'b0 || act.cs !== 8'd4) begin
      n_fails++;
      $display("FAIL md_timeout_idle: got err=%b fs=%b cs=%0d want 0 0 4", act.err, act.fs, act.cs);
    end
  endtask

  task automatic test_md_reset();
    do_reset();
    E_valid = 1; E_md = 1;
    run_cycle();
    run_cycle();
    rst_n = 0;
    run_cycle();
    n_checks++;
    if (act !== '0) begin
      n_fails++;
      $display("FAIL md_reset_outputs: got %h want 0", act);
    end
    rst_n = 1; E_md = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      n_checks++;
      if (act.err !== 1'b0 || act.fs !== 1'b0 || act.cc !== CW'(i)) begin
        n_fails++;
        $display("FAIL md_reset_after: cycle %0d got err=%b fs=%b cc=%0d want 0 0 %0d",
                 i, act.err, act.fs, act.cc, i);
      end
    end
    E_md = 1;
    run_cycle();
    n_checks++;
    if (act.start !== 1'b1) begin
      n_fails++;
      $display("FAIL md_restart: got %b want 1", act.start);
    end
    clear_inputs();
    md_done = 1;
    run_cycle();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) run_cycle();
    run_cycle();
    n_checks++;
    if (act.cc !== 8'd255) begin
      n_fails++;
      $display("FAIL wrap_max: got %0d want 255", act.cc);
    end
    run_cycle();
    n_checks++;
    if (act.cc !== 8'd0) begin
      n_fails++;
      $display("FAIL wrap_zero: got %0d want 0", act.cc);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst_n    = ($urandom_range(0, 399) != 0);
      D_rs1    = 5'($urandom_range(0, 3));
      D_rs2    = 5'($urandom_range(0, 3));
      D_use1   = 1'($urandom);
      D_use2   = 1'($urandom);
      E_valid  = ($urandom_range(0, 7) != 0);
      E_op     = 9'd1 << $urandom_range(0, 8);
      E_rd     = 5'($urandom_range(0, 3));
      E_md     = ($urandom_range(0, 7) == 0);
      e_cnd    = 1'($urandom);
      e_target = $urandom;
      md_done  = ($urandom_range(0, 4) == 0);
      run_cycle();
      n_checks++;
      if (act !== exp_o) begin
        n_fails++;
        $display("FAIL random[%0d]: got %h want %h", i, act, exp_o);
      end
    end
    rst_n = 1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_redirect_load_use();
    test_md_normal();
    test_md_timeout();
    test_md_reset();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the five-stage (F/D/E/M/W) core. It watches the Decode and Execute stages and the ALU's branch outcome. From these it drives the per-stage stall/bubble controls and the fetch redirect, and it sequences the multi-cycle mul/div unit attached beside the ALU in E with a start/done handshake and a watchdog. It also keeps free-running performance counters for cycles, stalls and flushes.

## Interface
- CNT_WIDTH, 32, width of each performance counter
- MD_TIMEOUT, 64, maximum BUSY cycles allowed before the watchdog aborts a mul/div operation (must be ≥ 2)
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- D_rs1_i, D_rs2_i  in  5  source registers of the instruction in D
- D_use_rs1_i, D_use_rs2_i  in  1  D instruction actually reads rs1 / rs2
- E_valid_i  in  1  E holds a real (non-bubble) instruction
- E_op_info_i  in  9  E opcode one-hot: [2] load, [4] branch, [5] jal, [6] jalr (other bits ignored)
- E_rd_i  in  5  destination register of the E instruction
- E_md_i  in  1  E instruction is mul/div
- e_cnd_i  in  1  ALU branch-condition result for the E instruction
- e_target_i  in  `PC_WIDTH  branch/jump target computed in E
- md_done_i  in  1  mul/div unit result ready
- md_start_o  out  1  start pulse to the mul/div unit
- md_err_o  out  1  one-cycle watchdog abort pulse
- F_stall_o, D_stall_o, E_stall_o  out  1  hold the stage register
- D_bubble_o, E_bubble_o, M_bubble_o  out  1  load a NOP into the stage register at the next edge
- f_redirect_o  out  1  fetch takes f_redirect_pc_o next
- f_redirect_pc_o  out  `PC_WIDTH  redirect target
- cnt_cycle_o, cnt_stall_o, cnt_flush_o  out  CNT_WIDTH  performance counters

## Operation
- **Load-use hazard:**
  - load_use = E_valid & E_op_info[2] & (E_rd≠0) & ((D_use_rs1 & D_rs1==E_rd) | (D_use_rs2 & D_rs2==E_rd)).
  - Response: F_stall, D_stall, E_bubble for that cycle.
- **Redirect:**
  - taken = E_valid & ((E_op_info[4] & e_cnd_i) | E_op_info[5] | E_op_info[6]).
  - Response: f_redirect_o=1, f_redirect_pc_o=e_target_i, D_bubble, E_bubble.
  - f_redirect_pc_o is e_target_i whenever f_redirect_o=1, and 0 otherwise.
- **Mul/div FSM, states IDLE and BUSY:**
  - **IDLE:**
    - If E_valid & E_md_i: md_start_o=1 (combinational, one cycle), F/D/E stall, M_bubble, next state BUSY, watchdog cleared to 0.
    - Otherwise remain in IDLE.
  - **BUSY:**
    - md_done_i is sampled only in BUSY.
    - If md_done_i=1: all stalls and M_bubble are released this cycle, so E advances and the result flows to M. Next state IDLE.
    - Else if watchdog == MD_TIMEOUT−1: md_err_o=1, F/D stalls released, E advances, M_bubble stays asserted (result discarded). Next state IDLE.
    - Else: F/D/E stall, M_bubble, watchdog+1.
- **Priority:** mul/div (start or BUSY) > redirect > load-use.
  - While the mul/div unit owns the pipe, redirect and load-use outputs are suppressed.
  - A redirect coinciding with load-use gives redirect outputs only; no stall.
- **Counters:**
  - cnt_cycle increments every cycle after reset.
  - cnt_stall increments each cycle F_stall_o=1.
  - cnt_flush increments each cycle f_redirect_o=1.
  - All counters wrap from 2^CNT_WIDTH−1 to 0.

## Timing
- **Reset (rst_n=0 at a rising edge):**
  - FSM goes to IDLE; watchdog and all counters go to 0.
  - While rst_n=0, every output is 0, including the combinational ones.
- Reset mid-BUSY aborts the operation silently: no md_err_o, and no md_start_o until a new IDLE detection.
- Load-use and redirect outputs are combinational, same cycle as the inputs. Load-use costs exactly 1 bubble; redirect costs 2 flushed slots.
- A mul/div operation stalls E for 1 + (BUSY cycles before done). With done in the first BUSY cycle, that is 1 stall cycle.
- A watchdog abort occurs on the MD_TIMEOUT-th BUSY cycle.
- md_start_o never asserts in BUSY, and never twice for the same instruction: E advances on the exit edge, so IDLE sees a new instruction.
- Counters are registered and update at the edge following the counted cycle.

## Test plan
- **Load-use:** E = load with rd=5, D reads rs2=5 with D_use_rs2=1 → F_stall=D_stall=E_bubble=1 for one cycle, cnt_stall=1. Repeat with rd=0 → no stall.
- **Taken branch:** E_op_info[4]=1, e_cnd_i=1, e_target_i=0x80000040 → f_redirect_o=1, pc=0x80000040, D_bubble=E_bubble=1, cnt_flush 0→1. Repeat with e_cnd_i=0 → all outputs 0.
- **Redirect plus load-use in the same cycle:** jalr in E (which writes rd=5) and D reads rs1=5 → redirect outputs only; F_stall=0, cnt_stall unchanged.
- **Mul/div completing normally:** E_md=1; md_done_i raised on the 3rd BUSY cycle → md_start_o pulses once; stalls held for 3 cycles (start cycle + 2 BUSY), released on the done cycle; M_bubble=0 on the done cycle; cnt_stall=3.
- **Watchdog abort:** MD_TIMEOUT=4, md_done_i never asserted → md_err_o pulses on the 4th BUSY cycle, M_bubble=1 on that cycle, state returns to IDLE. Second case: rst_n low on BUSY cycle 2 → all outputs 0 and counters 0 on the next cycle, no md_err_o.
